// File: rtl/sequence_player_if.sv
// Handshake and symbol bus between a game controller (master) and the
// sequence player (slave). The controller issues start/abort with a length
// and seed; the player returns the symbol stream and its status flags.
interface sequence_player_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] length;
  logic [7:0]       seed;
  logic [1:0]       num;
  logic             pressed;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, length, seed,
    input  num, pressed, busy, done
  );

  modport slave (
    input  start, abort, length, seed,
    output num, pressed, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// Plays a pseudo-random sequence of 2-bit symbols as {num, pressed} pulses.
// The sequence is regenerated from an 8-bit LFSR seed, so nothing is stored:
// each symbol is shown for ON_CYCLES cycles followed by an OFF_CYCLES gap.
// All outputs are registered from the next-state values.
module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  sequence_player_if.slave   bus
);

  localparam int ON_W  = (ON_CYCLES  > 1) ? $clog2(ON_CYCLES)  : 1;
  localparam int OFF_W = (OFF_CYCLES > 1) ? $clog2(OFF_CYCLES) : 1;
  localparam int CNT_W = (ON_W > OFF_W) ? ON_W : OFF_W;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [7:0]       SEED_ZERO_SUB = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [LEN_W-1:0] idx, idx_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic [7:0]       lfsr, lfsr_nx;
  logic [1:0]       num_nx;
  logic             zero_done;

  logic [1:0]       num_q;
  logic             pressed_q;
  logic             busy_q;
  logic             done_q;

  // Fibonacci LFSR with taps 7,5,4,3; a zero seed would lock up, so it is
  // swapped for a fixed nonzero value when latched.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? SEED_ZERO_SUB : s;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Next-state, counter and symbol logic for the IDLE/ON/OFF/DONE player.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    len_nx    = len;
    lfsr_nx   = lfsr;
    num_nx    = num_q;
    zero_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            state_nx = S_ON;
            len_nx   = clamp_len(bus.length);
            lfsr_nx  = seed_fix(bus.seed);
            num_nx   = seed_fix(bus.seed) & 8'h03;
            idx_nx   = '0;
            cnt_nx   = '0;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      S_ON: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == ON_LAST) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_OFF: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == OFF_LAST) begin
          cnt_nx = '0;
          if (idx == len - 1'b1) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_ON;
            idx_nx   = idx + 1'b1;
            lfsr_nx  = lfsr_step(lfsr);
            num_nx   = lfsr_step(lfsr) & 8'h03;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Control state, counters and registered outputs; reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      num_q     <= '0;
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      num_q     <= num_nx;
      pressed_q <= (state_nx == S_ON);
      busy_q    <= (state_nx == S_ON) || (state_nx == S_OFF);
      done_q    <= (state_nx == S_DONE) || zero_done;
    end
  end

  // Sequence data registers; only meaningful while a run is active.
  always_ff @(posedge clk) begin
    len  <= len_nx;
    lfsr <= lfsr_nx;
  end

  assign bus.num     = num_q;
  assign bus.pressed = pressed_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player with ON_CYCLES=4, OFF_CYCLES=2.
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sequence_player_if #(.LEN_W(5)) bus ();

  sequence_player #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .MAX_LEN   (MAXL),
    .LEN_W     (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference model: a run is described by its start point, clamped length
  // and seed; outputs follow from the position inside the run.
  bit         m_run, m_indone;
  int         m_pos, m_len;
  logic [7:0] m_seed;
  logic [1:0] e_num;
  logic       e_pressed, e_busy, e_done;

  function automatic logic [1:0] sym_of(input logic [7:0] sd, input int i);
    logic [7:0] l;
    l = sd;
    repeat (i) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l[1:0];
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit a,
                            input logic [4:0] len, input logic [7:0] sd);
    e_done = 1'b0;
    if (r) begin
      m_run = 0; m_indone = 0;
      e_num = 2'd0; e_pressed = 1'b0; e_busy = 1'b0;
    end else if (m_run) begin
      if (a) begin
        m_run = 0; e_pressed = 1'b0; e_busy = 1'b0;
      end else begin
        m_pos++;
        if (m_pos > m_len * P) begin
          m_run = 0; m_indone = 1;
          e_done = 1'b1; e_pressed = 1'b0; e_busy = 1'b0;
        end else begin
          e_busy    = 1'b1;
          e_pressed = ((m_pos - 1) % P) < ON;
          e_num     = sym_of(m_seed, (m_pos - 1) / P);
        end
      end
    end else if (m_indone) begin
      m_indone = 0;
    end else if (s) begin
      if (len == 0) begin
        e_done = 1'b1;
      end else begin
        m_run  = 1;
        m_pos  = 1;
        m_len  = (int'(len) > MAXL) ? MAXL : int'(len);
        m_seed = (sd == 8'h00) ? 8'hA5 : sd;
        e_busy = 1'b1; e_pressed = 1'b1;
        e_num  = sym_of(m_seed, 0);
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a,
                      input logic [4:0] len, input logic [7:0] sd);
    @(negedge clk);
    rst = r; bus.start = s; bus.abort = a; bus.length = len; bus.seed = sd;
    @(posedge clk);
    model_edge(r, s, a, len, sd);
    #1;
    chk("model", {27'd0, bus.num, bus.pressed, bus.busy, bus.done},
                 {27'd0, e_num, e_pressed, e_busy, e_done});
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  typedef struct {
    logic [4:0] length;
    logic [7:0] seed;
    int         n;
    logic [1:0] s [5];
  } vec_t;

  vec_t vecs [6];
  logic [1:0] obs [32];

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.length = '0; bus.seed = '0;

    // Reset held with start asserted: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd5, 8'h01);
      chk("rst_outputs", {28'd0, bus.num, bus.pressed, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
    end
    idle_step();
    chk("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    vecs[0] = '{length: 5'd5,  seed: 8'h01, n: 5,  s: '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1}};
    vecs[1] = '{length: 5'd1,  seed: 8'h00, n: 1,  s: '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{length: 5'd0,  seed: 8'h37, n: 0,  s: '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[3] = '{length: 5'd3,  seed: 8'hA5, n: 3,  s: '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0}};
    vecs[4] = '{length: 5'd31, seed: 8'h01, n: 16, s: '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1}};
    vecs[5] = '{length: 5'd2,  seed: 8'h01, n: 2,  s: '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0}};

    foreach (vecs[v]) begin
      int nsym, done_cyc, done_n;
      bit saw_busy, prev_p;
      nsym = 0; done_cyc = -1; done_n = 0; saw_busy = 0; prev_p = 0;
      step(1'b0, 1'b1, 1'b0, vecs[v].length, vecs[v].seed);
      for (int c = 1; c <= vecs[v].n * P + 3; c++) begin
        if (bus.pressed && !prev_p && nsym < 32) begin
          obs[nsym] = bus.num;
          nsym++;
        end
        prev_p = bus.pressed;
        if (bus.busy) saw_busy = 1;
        if (bus.done) begin
          done_n++;
          if (done_cyc < 0) done_cyc = c;
        end
        idle_step();
      end
      chk($sformatf("vec%0d_nsym", v), nsym, vecs[v].n);
      chk($sformatf("vec%0d_done_cycle", v), done_cyc, vecs[v].n * P + 1);
      chk($sformatf("vec%0d_done_count", v), done_n, 1);
      if (vecs[v].n == 0) chk("len0_busy", {31'd0, saw_busy}, 32'd0);
      for (int i = 0; i < 5 && i < vecs[v].n; i++)
        chk($sformatf("vec%0d_sym%0d", v, i), {30'd0, obs[i]}, {30'd0, vecs[v].s[i]});
    end

    // Abort during the second symbol's ON phase, then replay from symbol 0.
    begin
      int dn;
      step(1'b0, 1'b1, 1'b0, 5'd5, 8'h01);
      for (int i = 0; i < 7; i++) idle_step();
      chk("abort_pre_pressed", {29'd0, bus.pressed, bus.num}, {29'd0, 1'b1, 2'd2});
      step(1'b0, 1'b0, 1'b1, 5'd0, 8'd0);
      chk("abort_outputs", {29'd0, bus.pressed, bus.busy, bus.done}, 32'd0);
      dn = 0;
      for (int i = 0; i < 15; i++) begin
        idle_step();
        if (bus.done) dn++;
      end
      chk("abort_no_done", dn, 0);
      step(1'b0, 1'b1, 1'b0, 5'd5, 8'h01);
      chk("replay_first", {29'd0, bus.pressed, bus.num}, {29'd0, 1'b1, 2'd1});
      for (int i = 0; i < 32; i++) idle_step();
    end

    // start pulsed mid-playback and in the DONE cycle is ignored.
    begin
      step(1'b0, 1'b1, 1'b0, 5'd2, 8'h01);
      for (int c = 2; c <= 13; c++) begin
        if (c == 3 || c == 8 || c == 13) step(1'b0, 1'b1, 1'b0, 5'd7, 8'h33);
        else idle_step();
        if (c == 7)  chk("mid_sym2", {29'd0, bus.pressed, bus.num}, {29'd0, 1'b1, 2'd2});
        if (c == 12) chk("mid_no_early_done", {31'd0, bus.done}, 32'd0);
        if (c == 13) chk("mid_done_timing", {30'd0, bus.done, bus.busy}, {30'd0, 1'b1, 1'b0});
      end
      step(1'b0, 1'b1, 1'b0, 5'd7, 8'h33);
      chk("done_cycle_start_ignored", {30'd0, bus.busy, bus.pressed}, 32'd0);
      for (int i = 0; i < 3; i++) idle_step();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      bit r, s, a;
      logic [4:0] l;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      step(r, s, a, l, 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
